// File: rtl/div_sched_pkg.sv
// Shared types for the divider scheduler: FSM state encoding and the
// round-robin pick helper used by every arbiter in this slice.
package div_sched_pkg;

  localparam int RR_MAX   = 16;
  localparam int RR_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT,
    ST_RESP
  } div_sched_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit at or after ptr, wrapping at n. Requests above n are ignored.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t pick;
    int       idx;
    pick = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !pick.found && req[idx]) begin
        pick.found = 1'b1;
        pick.idx   = RR_IDX_W'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: grants the first requester at or
// after ptr, returning the grant both one-hot and as an index.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [RR_MAX-1:0] req_ext;
  rr_pick_t          pick;

  always_comb begin
    req_ext             = '0;
    req_ext[N-1:0]      = req;
    pick                = rr_pick(req_ext, RR_IDX_W'(ptr), N);
    gnt_vld             = pick.found;
    gnt_idx             = IDX_W'(pick.idx);
    gnt_onehot          = '0;
    gnt_onehot[gnt_idx] = pick.found;
  end

endmodule

// File: rtl/div_sched.sv
// Shares one integer divider between N requesters: round-robin accept, hold
// operands, wait for the result, and return exactly one response per accept.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int N       = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_vld,
  input  logic [N*WIDTH-1:0] req_dvd,
  input  logic [N*WIDTH-1:0] req_dvs,
  output logic [N-1:0]       req_rdy,
  output logic [N-1:0]       rsp_vld,
  output logic [WIDTH-1:0]   rsp_quo,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   div_dvd,
  output logic [WIDTH-1:0]   div_dvs,
  input  logic [WIDTH-1:0]   div_quo,
  input  logic               div_rdy,
  output logic               busy
);

  localparam int IDX_W   = $clog2(N);
  localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  div_sched_state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] op_dvd_q, op_dvd_d;
  logic [WIDTH-1:0] op_dvs_q, op_dvs_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [N-1:0]     gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic [WIDTH-1:0] sel_dvd, sel_dvs;

  rr_arbiter #(.N(N)) u_arb (
    .req        (req_vld),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_vld    (gnt_vld)
  );

  // NOTE: every signal written here is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_d     = cur_q;
    op_dvd_d  = op_dvd_q;
    op_dvs_d  = op_dvs_q;
    res_quo_d = res_quo_q;
    res_err_d = res_err_q;
    cnt_d     = cnt_q;
    req_rdy   = '0;
    rsp_vld   = '0;
    sel_dvd   = req_dvd[int'(gnt_idx)*WIDTH +: WIDTH];
    sel_dvs   = req_dvs[int'(gnt_idx)*WIDTH +: WIDTH];

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          req_rdy  = gnt_onehot;
          op_dvd_d = sel_dvd;
          op_dvs_d = sel_dvs;
          cur_d    = gnt_idx;
          // A zero divisor is answered locally; the divider is never consulted.
          if (sel_dvs == '0) begin
            res_quo_d = '1;
            res_err_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (div_rdy) begin
          res_quo_d = div_quo;
          res_err_d = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_quo_d = '0;
          res_err_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        rsp_vld[cur_q] = 1'b1;
        ptr_d          = (cur_q == IDX_W'(N - 1)) ? '0 : cur_q + 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cur_q     <= '0;
      op_dvd_q  <= '0;
      op_dvs_q  <= '0;
      res_quo_q <= '0;
      res_err_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      op_dvd_q  <= op_dvd_d;
      op_dvs_q  <= op_dvs_d;
      res_quo_q <= res_quo_d;
      res_err_q <= res_err_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign div_dvd = op_dvd_q;
  assign div_dvs = op_dvs_q;
  assign rsp_quo = res_quo_q;
  assign rsp_err = res_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched with a behavioural divider whose latency
// and ready behaviour can be switched between normal, stuck-high and stuck-low.
module tb_div_sched;

  localparam int W  = 12;
  localparam int NR = 4;
  localparam int S  = 2;
  localparam int TO = 64;

  typedef enum int {DIV_NORMAL, DIV_HI, DIV_LO} div_mode_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_vld = '0;
  logic [NR*W-1:0] req_dvd, req_dvs;
  logic [NR-1:0]   req_rdy, rsp_vld;
  logic [W-1:0]    rsp_quo, div_dvd, div_dvs, div_quo;
  logic            rsp_err, div_rdy, busy;

  logic [W-1:0] t_dvd [NR];
  logic [W-1:0] t_dvs [NR];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  logic [W-1:0] last_dvd = '0;
  logic [W-1:0] last_dvs = '0;

  div_mode_t div_mode = DIV_NORMAL;
  int        div_lat  = 3;

  div_sched #(.WIDTH(W), .N(NR), .SETTLE(S), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_dvd (req_dvd),
    .req_dvs (req_dvs),
    .req_rdy (req_rdy),
    .rsp_vld (rsp_vld),
    .rsp_quo (rsp_quo),
    .rsp_err (rsp_err),
    .div_dvd (div_dvd),
    .div_dvs (div_dvs),
    .div_quo (div_quo),
    .div_rdy (div_rdy),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_dvd = '0;
    req_dvs = '0;
    for (int i = 0; i < NR; i++) begin
      req_dvd[i*W +: W] = t_dvd[i];
      req_dvs[i*W +: W] = t_dvs[i];
    end
  end

  // Divider stand-in: result appears div_lat cycles after it notices new operands.
  function automatic logic [W-1:0] true_div(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? '0 : a / b;
  endfunction

  logic [W-1:0] m_prev_dvd = '0;
  logic [W-1:0] m_prev_dvs = '0;
  logic [W-1:0] m_quo_q    = '0;
  logic         m_rdy_q    = 1'b0;
  int           m_cnt      = 0;

  always @(posedge clk) begin
    if (div_dvd != m_prev_dvd || div_dvs != m_prev_dvs) begin
      m_prev_dvd <= div_dvd;
      m_prev_dvs <= div_dvs;
      m_cnt      <= div_lat;
      m_rdy_q    <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_rdy_q <= 1'b1;
        m_quo_q <= true_div(div_dvd, div_dvs);
      end
    end
  end

  assign div_rdy = (div_mode == DIV_HI) ? 1'b1 : (div_mode == DIV_LO) ? 1'b0 : m_rdy_q;
  assign div_quo = (div_mode == DIV_NORMAL) ? m_quo_q : true_div(div_dvd, div_dvs);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    req_vld = '0;
    @(posedge clk);
    #1;
    chk("rst_req_rdy", 32'(req_rdy), 0);
    chk("rst_rsp_vld", 32'(rsp_vld), 0);
    chk("rst_rsp_quo", 32'(rsp_quo), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_div_dvd", 32'(div_dvd), 0);
    chk("rst_div_dvs", 32'(div_dvs), 0);
    chk("rst_busy",    32'(busy), 0);
    rst      = 1'b0;
    m_ptr    = 0;
    last_dvd = '0;
    last_dvs = '0;
    tick();
  endtask

  // Serve n_ops requests from the currently raised req_vld bits, predicting the
  // grant order, result and latency of each from the scheduling rules.
  task automatic serve(input int n_ops, input logic [NR-1:0] persist);
    int          w, t0, lat, exp_lat;
    logic [W-1:0] dvd, dvs, exp_quo;
    logic        exp_err, overlap;
    #1;
    for (int op = 0; op < n_ops; op++) begin
      w = model_pick(req_vld, m_ptr);
      if (w < 0) break;
      for (int k = 0; k < 16 && req_rdy == '0; k++) tick();
      chk("req_rdy_grant", 32'(req_rdy), 32'(1 << w));
      chk("busy_at_accept", 32'(busy), 0);
      dvd = t_dvd[w];
      dvs = t_dvs[w];
      t0  = cyc;
      if (dvs == '0) begin
        exp_quo = '1; exp_err = 1'b1; exp_lat = 1;
      end else if (div_mode == DIV_HI) begin
        exp_quo = dvd / dvs; exp_err = 1'b0; exp_lat = S + 2;
      end else if (div_mode == DIV_LO) begin
        exp_quo = '0; exp_err = 1'b1; exp_lat = S + TO + 1;
      end else begin
        exp_quo = dvd / dvs; exp_err = 1'b0;
        if (dvd == last_dvd && dvs == last_dvs) exp_lat = S + 2;
        else exp_lat = (div_lat + 3 > S + 2) ? div_lat + 3 : S + 2;
      end
      last_dvd = dvd;
      last_dvs = dvs;
      @(posedge clk);
      #1;
      if (!persist[w] || op == n_ops - 1) begin
        req_vld[w] = 1'b0;
        t_dvd[w]   = W'($urandom);
        t_dvs[w]   = W'($urandom);
      end
      tick();
      chk("busy_after_accept", 32'(busy), 1);
      chk("div_dvd_hold", 32'(div_dvd), 32'(dvd));
      chk("div_dvs_hold", 32'(div_dvs), 32'(dvs));
      overlap = 1'b0;
      for (int k = 0; k < 200 && rsp_vld == '0; k++) begin
        if (req_rdy != '0) overlap = 1'b1;
        tick();
      end
      lat = cyc - t0;
      chk("rsp_vld_onehot", 32'(rsp_vld), 32'(1 << w));
      chk("rsp_quo", 32'(rsp_quo), 32'(exp_quo));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_latency", 32'(lat), 32'(exp_lat));
      chk("no_accept_while_busy", 32'(overlap), 0);
      m_ptr = (w + 1) % NR;
      tick();
      chk("rsp_single_pulse", 32'(rsp_vld), 0);
    end
  endtask

  initial begin
    logic [NR-1:0] mask;
    logic          quiet;
    for (int i = 0; i < NR; i++) begin
      t_dvd[i] = '0;
      t_dvs[i] = '0;
    end
    do_reset();

    // Basic divide, then a second op from the same requester.
    t_dvd[0] = 12'd255; t_dvs[0] = 12'd3; req_vld[0] = 1'b1;
    serve(1, '0);
    t_dvd[0] = 12'd255; t_dvs[0] = 12'd5; req_vld[0] = 1'b1;
    serve(1, '0);

    // Zero divisor is answered the cycle after accept.
    t_dvd[2] = 12'd100; t_dvs[2] = 12'd0; req_vld[2] = 1'b1;
    serve(1, '0);

    // Three simultaneous requesters from ptr 0.
    do_reset();
    t_dvd[0] = 12'd1000; t_dvs[0] = 12'd10;
    t_dvd[1] = 12'd1000; t_dvs[1] = 12'd8;
    t_dvd[3] = 12'd1000; t_dvs[3] = 12'd4;
    req_vld = 4'b1011;
    serve(3, '0);

    // Persistent requester 0 alternates with a one-shot requester 1.
    do_reset();
    t_dvd[0] = 12'd7; t_dvs[0] = 12'd2;
    t_dvd[1] = 12'd9; t_dvs[1] = 12'd3;
    req_vld = 4'b0011;
    serve(3, 4'b0001);

    // Ready stuck high: result only sampled once WAIT is reached.
    div_mode = DIV_HI;
    t_dvd[1] = 12'd3001; t_dvs[1] = 12'd17; req_vld[1] = 1'b1;
    serve(1, '0);

    // Ready stuck low: timeout error.
    div_mode = DIV_LO;
    t_dvd[2] = 12'd999; t_dvs[2] = 12'd9; req_vld[2] = 1'b1;
    serve(1, '0);

    // Randomized rounds against the reference model.
    div_mode = DIV_NORMAL;
    for (int r = 0; r < 8; r++) begin
      div_lat = int'($urandom_range(1, 8));
      mask    = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) begin
        t_dvd[i] = W'($urandom);
        t_dvs[i] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 40));
      end
      req_vld = mask;
      serve($countones(mask), '0);
    end

    // Reset while waiting on the divider drops the op and clears ptr.
    div_lat  = 3;
    t_dvd[2] = 12'd500; t_dvs[2] = 12'd7; req_vld[2] = 1'b1;
    serve(1, '0);
    div_mode = DIV_LO;
    t_dvd[3] = 12'd255; t_dvs[3] = 12'd3; req_vld[3] = 1'b1;
    #1;
    for (int k = 0; k < 16 && req_rdy == '0; k++) tick();
    chk("inflight_accept", 32'(req_rdy), 32'(4'b1000));
    @(posedge clk);
    #1;
    req_vld[3] = 1'b0;
    repeat (S + 4) tick();
    chk("inflight_busy", 32'(busy), 1);
    do_reset();
    quiet = 1'b1;
    repeat (10) begin
      if (rsp_vld != '0 || busy != 1'b0) quiet = 1'b0;
      tick();
    end
    chk("no_rsp_after_reset", 32'(quiet), 1);
    div_mode = DIV_NORMAL;
    t_dvd[1] = W'($urandom); t_dvs[1] = W'($urandom_range(1, 40));
    t_dvd[3] = W'($urandom); t_dvs[3] = W'($urandom_range(1, 40));
    req_vld  = 4'b1010;
    serve(2, '0);
    t_dvd[0] = 12'd255; t_dvs[0] = 12'd3; req_vld[0] = 1'b1;
    serve(1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
